// File: rtl/uart_alu_sequencer.sv
// Frames three UART RX bytes (A, B, opcode) into the ALU and launches the result on UART TX.
// A partial frame that stalls past TIMEOUT_CLKS is dropped, and bytes that arrive while busy are flagged.
module uart_alu_sequencer #(
    parameter int unsigned NB_DATA      = 8,
    parameter int unsigned NB_OP        = 6,
    parameter int unsigned TIMEOUT_CLKS = 1000000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx_done_tick,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done_tick,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_error
);

    localparam int unsigned CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WAIT_B  = 3'd1;
    localparam logic [2:0] ST_WAIT_OP = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_WAIT_TX = 3'd4;

    logic [2:0]         state_q,   state_d;
    logic [NB_DATA-1:0] data_a_q,  data_a_d;
    logic [NB_DATA-1:0] data_b_q,  data_b_d;
    logic [NB_OP-1:0]   op_q,      op_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               error_q,   error_d;
    logic               settle_q,  settle_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               timeout_hit;

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CLKS - 1));

    // State and output registers
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            data_a_q   <= '0;
            data_b_q   <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            error_q    <= 1'b0;
            settle_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            op_q       <= op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            error_q    <= error_d;
            settle_q   <= settle_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        op_d       = op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        error_d    = 1'b0;
        settle_d   = 1'b0;
        cnt_d      = '0;

        case (state_q)
            ST_IDLE: begin
                if (i_rx_done_tick) begin
                    data_a_d = i_rx_data;
                    state_d  = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (i_rx_done_tick) begin
                    data_b_d = i_rx_data;
                    state_d  = ST_WAIT_OP;
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            ST_WAIT_OP: begin
                if (i_rx_done_tick) begin
                    op_d    = i_rx_data[NB_OP-1:0];
                    state_d = ST_EXEC;
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            ST_EXEC: begin
                // First clock lets the ALU settle on the new opcode; the second captures its result.
                if (!settle_q) begin
                    settle_d = 1'b1;
                end else begin
                    tx_data_d  = i_alu_result;
                    tx_start_d = 1'b1;
                    state_d    = ST_WAIT_TX;
                end
                if (i_rx_done_tick) begin
                    error_d = 1'b1;
                end
            end
            ST_WAIT_TX: begin
                if (i_tx_done_tick) begin
                    state_d = ST_IDLE;
                end
                if (i_rx_done_tick) begin
                    error_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_data_a   = data_a_q;
    assign o_data_b   = data_b_q;
    assign o_op       = op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_error    = error_q;
    assign o_busy     = (state_q != ST_IDLE);

endmodule
